// File: rtl/laser_receiver.sv
// ---------------------------------------------------------------------------
// laser_receiver
//
// Target-side end of the laser link. The raw photodiode comparator output is
// synchronized, debounced into a clean "lit" level, and a sustained lit period
// is qualified as a hit. Each hit produces a one-cycle strobe, bumps a hit
// counter and opens an invulnerability window. After the window the receiver
// waits for the beam to go dark so one continuous beam cannot score twice.
//
// Ports:
//   clock      in   system clock (50 MHz nominal)
//   reset      in   synchronous, active-high reset
//   enable     in   1 = detection armed, 0 = hits suppressed
//   sensor     in   raw photodiode comparator, asynchronous, 1 = illuminated
//   lit        out  debounced sensor level
//   hit        out  one-cycle strobe per qualified hit
//   hit_count  out  total qualified hits since reset (COUNT_W bits)
//   invuln     out  high while the invulnerability window is active
//
// Optional feature (compile-time macro LASER_RX_SATURATE_EN):
//   defined   -> hit_count saturates at all-ones
//   undefined -> hit_count wraps modulo 2**COUNT_W
//
// Debug visibility: the FSM state register is the signal "state"
// (encoding IDLE=0, QUAL=1, HIT=2, INVULN=3, WAIT_DARK=4).
// ---------------------------------------------------------------------------
module laser_receiver #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int MIN_ON_CYCLES   = 2500000,
  parameter int INVULN_CYCLES   = 100000000,
  parameter int COUNT_W         = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               sensor,
  output logic               lit,
  output logic               hit,
  output logic [COUNT_W-1:0] hit_count,
  output logic               invuln
);

  // Counter widths: $clog2 of the parameter, never narrower than one bit.
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int QW = (MIN_ON_CYCLES   > 1) ? $clog2(MIN_ON_CYCLES)   : 1;
  localparam int IW = (INVULN_CYCLES   > 1) ? $clog2(INVULN_CYCLES)   : 1;

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [QW-1:0] QUAL_LAST = QW'(MIN_ON_CYCLES - 1);
  localparam logic [IW-1:0] INV_LAST  = IW'(INVULN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    QUAL      = 3'd1,
    HIT       = 3'd2,
    INVULN    = 3'd3,
    WAIT_DARK = 3'd4
  } state_t;

  // -------------------------------------------------------------------------
  // Synchronizer: sensor enters at bit 0 and leaves at the top bit.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sensor};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Debounce: lit follows sync_s only after sync_s has disagreed with lit for
  // DEBOUNCE_CYCLES consecutive cycles. Any agreement restarts the count.
  // -------------------------------------------------------------------------
  logic [DW-1:0] db_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      db_cnt <= '0;
      lit    <= 1'b0;
    end else if (sync_s == lit) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      lit    <= sync_s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Hit FSM
  // -------------------------------------------------------------------------
  state_t        state;
  state_t        state_next;
  logic [QW-1:0] qual_cnt;
  logic [QW-1:0] qual_next;
  logic [IW-1:0] inv_cnt;
  logic [IW-1:0] inv_next;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      qual_cnt <= '0;
      inv_cnt  <= '0;
    end else begin
      state    <= state_next;
      qual_cnt <= qual_next;
      inv_cnt  <= inv_next;
    end
  end

  always_comb begin
    state_next = state;
    qual_next  = qual_cnt;
    inv_next   = inv_cnt;

    unique case (state)
      IDLE: begin
        if (lit && enable) begin
          state_next = QUAL;
          // The entering cycle already counts as the first lit cycle.
          qual_next  = QW'(1);
        end
      end

      QUAL: begin
        if (lit && enable) begin
          if (qual_cnt == QUAL_LAST) begin
            state_next = HIT;
            qual_next  = '0;
          end else begin
            qual_next  = qual_cnt + QW'(1);
          end
        end else begin
          state_next = IDLE;
          qual_next  = '0;
        end
      end

      HIT: begin
        // The window counter is cleared here so INVULN starts from zero.
        state_next = INVULN;
        inv_next   = '0;
      end

      INVULN: begin
        // lit and enable are deliberately ignored: the window always runs
        // its full length once started.
        if (inv_cnt == INV_LAST) begin
          state_next = WAIT_DARK;
        end else begin
          inv_next   = inv_cnt + IW'(1);
        end
      end

      WAIT_DARK: begin
        // Require the beam to drop before re-arming.
        if (!lit) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        qual_next  = '0;
        inv_next   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registered hit strobe and hit counter. Both update on the edge that
  // enters HIT, so hit is high exactly while the FSM sits in HIT and the
  // count is already incremented alongside the strobe.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      hit       <= 1'b0;
      hit_count <= '0;
    end else begin
      hit <= (state_next == HIT);
      if (state_next == HIT) begin
`ifdef LASER_RX_SATURATE_EN
        if (hit_count != {COUNT_W{1'b1}}) begin
          hit_count <= hit_count + COUNT_W'(1);
        end
`else
        hit_count <= hit_count + COUNT_W'(1);
`endif
      end
    end
  end

  assign invuln = (state == INVULN);

endmodule

// File: tb/tb_laser_receiver.sv
// ---------------------------------------------------------------------------
// tb_laser_receiver
//
// Directed bench for laser_receiver with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// MIN_ON_CYCLES=10, INVULN_CYCLES=20, COUNT_W=4. Cycle i of a beam is the
// i-th rising edge after the sensor is first driven; with these parameters
// lit rises at cycle 6, hit pulses at cycle 16 and invuln spans 20 cycles.
// ---------------------------------------------------------------------------
module tb_laser_receiver;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       sensor = 1'b0;
  logic       lit;
  logic       hit;
  logic [3:0] hit_count;
  logic       invuln;

  int tests = 0;
  int fails = 0;

  int first_lit;
  int first_hit;
  int hits;
  int inv_c;

  laser_receiver #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .MIN_ON_CYCLES  (10),
    .INVULN_CYCLES  (20),
    .COUNT_W        (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .sensor   (sensor),
    .lit      (lit),
    .hit      (hit),
    .hit_count(hit_count),
    .invuln   (invuln)
  );

  // Clock
  always #5 clock = ~clock;

  // Advance one edge and settle past it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one beam: sensor high for cycles 1..on_c, enable low for cycles
  // in [lo_s, lo_e). Records the first lit cycle, first hit cycle (-1 if
  // none), number of hit pulses and number of invuln cycles.
  task automatic beam(input int on_c, input int total, input int lo_s, input int lo_e,
                      output int f_lit, output int f_hit, output int n_hit, output int n_inv);
    f_lit = -1;
    f_hit = -1;
    n_hit = 0;
    n_inv = 0;
    for (int i = 1; i <= total; i++) begin
      sensor = (i <= on_c);
      enable = !((i >= lo_s) && (i < lo_e));
      tick();
      if (lit && f_lit < 0) f_lit = i;
      if (hit) begin
        n_hit++;
        if (f_hit < 0) f_hit = i;
      end
      if (invuln) n_inv++;
    end
    sensor = 1'b0;
    enable = 1'b1;
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_lit", lit, 0);
    check("reset_hit", hit, 0);
    check("reset_count", hit_count, 0);
    check("reset_invuln", invuln, 0);
    check("reset_state", dut.state, 0);

    // Glitch rejection: 3-cycle pulse
    beam(3, 20, 0, 0, first_lit, first_hit, hits, inv_c);
    check("glitch_lit", first_lit, -1);
    check("glitch_hits", hits, 0);
    check("glitch_count", hit_count, 0);

    // Continuous 100-cycle beam: single hit with exact timing
    beam(100, 130, 0, 0, first_lit, first_hit, hits, inv_c);
    check("cont_lit_cycle", first_lit, 6);
    check("cont_hit_cycle", first_hit, 16);
    check("cont_hits", hits, 1);
    check("cont_invuln_len", inv_c, 20);
    check("cont_count", hit_count, 1);
    check("cont_lit_dark", lit, 0);

    // Second 20-cycle beam scores again
    beam(20, 60, 0, 0, first_lit, first_hit, hits, inv_c);
    check("second_hit_cycle", first_hit, 16);
    check("second_hits", hits, 1);
    check("second_count", hit_count, 2);

    // Short beam: lit for 8 cycles only
    beam(8, 30, 0, 0, first_lit, first_hit, hits, inv_c);
    check("short_lit_cycle", first_lit, 6);
    check("short_hits", hits, 0);
    check("short_count", hit_count, 2);
    check("short_state_idle", dut.state, 0);

    // Enable low for the whole beam
    beam(30, 50, 1, 1000, first_lit, first_hit, hits, inv_c);
    check("en_off_lit", first_lit, 6);
    check("en_off_hits", hits, 0);
    check("en_off_count", hit_count, 2);

    // Enable dropped at cycles 11-12 mid-QUAL: requalify from cycle 13
    beam(30, 70, 11, 13, first_lit, first_hit, hits, inv_c);
    check("en_qual_hit_cycle", first_hit, 22);
    check("en_qual_hits", hits, 1);
    check("en_qual_invuln_len", inv_c, 20);
    check("en_qual_count", hit_count, 3);

    // Enable dropped during INVULN: window keeps its full length
    beam(20, 60, 18, 60, first_lit, first_hit, hits, inv_c);
    check("en_inv_hit_cycle", first_hit, 16);
    check("en_inv_invuln_len", inv_c, 20);
    check("en_inv_count", hit_count, 4);

    // Wrap / saturate over 17 hits from reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("wrap_reset_count", hit_count, 0);
    for (int n = 1; n <= 17; n++) begin
      beam(20, 45, 0, 0, first_lit, first_hit, hits, inv_c);
      if (n == 15) check("wrap_count_15", hit_count, 15);
    end
    check("wrap_last_hits", hits, 1);
`ifdef LASER_RX_SATURATE_EN
    check("wrap_count_17", hit_count, 15);
`else
    check("wrap_count_17", hit_count, 1);
`endif

    // Reset in the middle of INVULN
    sensor = 1'b1;
    repeat (20) tick();
    check("midinv_invuln_before", invuln, 1);
    reset = 1'b1;
    tick();
    check("midinv_invuln_after", invuln, 0);
    check("midinv_count_after", hit_count, 0);
    check("midinv_lit_after", lit, 0);
    check("midinv_hit_after", hit, 0);
    reset = 1'b0;
    sensor = 1'b0;
    repeat (5) tick();
    check("post_reset_count", hit_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/laser_receiver.md
Name: laser_receiver

Overview:
Target-side end of the laser link. Watches a raw photodiode input and qualifies a sustained beam as a hit. On each hit it issues a one-cycle hit strobe, increments a hit counter, and enters an invulnerability window. Sits between the sensor header pin and the scoring/display logic, mirroring the 2 s ON / 2 s OFF emitter timing at 50 MHz.

Parameters:
SYNC_STAGES, 2, flip-flop stages synchronizing the asynchronous sensor pin (min 2)
DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to change the debounced level (1 ms)
MIN_ON_CYCLES, 2500000, debounced-lit cycles needed to qualify a hit (50 ms)
INVULN_CYCLES, 100000000, cycles after a hit during which new hits are ignored (2 s)
COUNT_W, 8, width of hit_count

Ports:
clock  input  1  system clock, 50 MHz
reset  input  1  synchronous, active-high reset
enable  input  1  1 = detection armed; 0 = hits suppressed
sensor  input  1  raw photodiode comparator, asynchronous, 1 = illuminated
lit  output  1  debounced sensor level
hit  output  1  one-cycle strobe per qualified hit
hit_count  output  COUNT_W  total qualified hits since reset
invuln  output  1  high while the invulnerability window is active

Behaviour:
- Reset values: lit=0, hit=0, hit_count=0, invuln=0, state=IDLE. All counters are cleared and the synchronizer chain is set to 0.
- Reset mid-operation (any state): on the next edge everything returns to its reset values. A hit in progress is not counted.
- Synchronizer: sensor passes through SYNC_STAGES flops, giving sync_s.
- Debounce:
  - A counter runs while sync_s != lit and clears to 0 whenever sync_s == lit.
  - When the counter reaches DEBOUNCE_CYCLES-1 with sync_s still different, lit takes sync_s on that edge and the counter clears.
  - Total latency from the sensor edge to lit is SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- FSM states are IDLE, QUAL, HIT, INVULN, WAIT_DARK.
  - IDLE: when lit=1 and enable=1, go to QUAL with qual_cnt=1.
  - QUAL: each cycle with lit=1 and enable=1, qual_cnt increments. If qual_cnt == MIN_ON_CYCLES-1 on such a cycle, go to HIT. If lit=0 or enable=0, go back to IDLE and clear qual_cnt.
  - HIT: lasts exactly one cycle. hit=1, hit_count increments, inv_cnt clears. Then go to INVULN.
  - INVULN: invuln=1 and inv_cnt increments. When inv_cnt == INVULN_CYCLES-1, go to WAIT_DARK. Both lit and enable are ignored.
  - WAIT_DARK: invuln=0. When lit=0, go to IDLE. This prevents one continuous beam from scoring twice.
- hit is registered. It is asserted only in HIT, so there is exactly one pulse per qualified hit.
- Hit timing: hit rises MIN_ON_CYCLES cycles after lit rises, provided enable=1 throughout.
- hit_count wraps modulo 2^COUNT_W by default; see Optional Feature.
- enable dropping during INVULN does not shorten the window.
- enable dropping during QUAL aborts qualification.
- Counter widths: qual_cnt, inv_cnt and the debounce counter are each sized with $clog2 of their parameter (minimum width 1).

Optional Feature:
Macro LASER_RX_SATURATE_EN.
- Defined: hit_count saturates at 2^COUNT_W-1. Further hits still pulse hit and enter INVULN, but the count holds.
- Undefined: hit_count wraps from 2^COUNT_W-1 to 0.

Test Plan:
All scenarios use SYNC_STAGES=2, DEBOUNCE_CYCLES=4, MIN_ON_CYCLES=10, INVULN_CYCLES=20, COUNT_W=4, enable=1 unless noted.
- Glitch rejection: sensor high for 3 cycles, then low -> lit stays 0, hit never asserts, hit_count=0.
- Single hit: sensor held high from cycle 0 -> lit rises at cycle 6 and hit pulses once at cycle 16. hit_count=1, invuln=1 for 20 cycles, then 0.
- Continuous beam: sensor high for 100 cycles -> exactly one hit and hit_count=1. After the sensor drops and lit falls, a second 20-cycle beam gives hit_count=2.
- Short beam: lit high for 8 cycles only -> no hit, FSM returns to IDLE.
- Enable gating: enable=0 during a 30-cycle beam -> no hit. Dropping enable mid-QUAL aborts the hit. Dropping enable during INVULN leaves invuln high for the full 20 cycles.
- Wrap/saturate and reset: 17 hits -> hit_count=1 without LASER_RX_SATURATE_EN, 15 with it. Asserting reset mid-INVULN -> invuln=0, hit_count=0 the next cycle.
